// File: rtl/pcs_transmit_pkg.sv
// Shared 1000BASE-X PCS definitions: code-group constants, state encodings
// and the sub-block running-disparity rules used by transmit and receive.
package pcs_transmit_pkg;

  typedef enum logic {
    RD_NEG = 1'b0,
    RD_POS = 1'b1
  } rd_t;

  typedef enum logic [2:0] {
    XMIT_IDLE = 3'd0,
    START_PKT = 3'd1,
    TX_DATA   = 3'd2,
    END_T     = 3'd3,
    END_R1    = 3'd4,
    END_R2    = 3'd5
  } state_t;

  // Octet values presented to the encoder for the special code groups.
  localparam logic [7:0] K28_5_OCTET = 8'hBC;
  localparam logic [7:0] K27_7_OCTET = 8'hFB;
  localparam logic [7:0] K29_7_OCTET = 8'hFD;
  localparam logic [7:0] K23_7_OCTET = 8'hF7;
  localparam logic [7:0] D16_2_OCTET = 8'h50;
  localparam logic [7:0] D5_6_OCTET  = 8'hC5;

  // Ten-bit code groups {a,b,c,d,e,i,f,g,h,j}, named by entering disparity.
  localparam logic [9:0] K28_5_NEG = 10'b0011111010;
  localparam logic [9:0] K28_5_POS = 10'b1100000101;
  localparam logic [9:0] K27_7_NEG = 10'b1101101000;
  localparam logic [9:0] K27_7_POS = 10'b0010010111;
  localparam logic [9:0] K29_7_NEG = 10'b1011101000;
  localparam logic [9:0] K29_7_POS = 10'b0100010111;
  localparam logic [9:0] K23_7_NEG = 10'b1110101000;
  localparam logic [9:0] K23_7_POS = 10'b0001010111;
  localparam logic [9:0] D16_2_NEG = 10'b0110110101;
  localparam logic [9:0] D16_2_POS = 10'b1001000101;
  localparam logic [9:0] D5_6      = 10'b1010010110;

  // A balanced sub-block keeps the disparity, except 000111/111000 and
  // 0011/1100 which force it to the sign of their trailing bits.
  function automatic rd_t rd_after_6b(input logic [5:0] blk, input rd_t rd_in);
    int ones;
    ones = $countones(blk);
    if (ones > 3)             return RD_POS;
    else if (ones < 3)        return RD_NEG;
    else if (blk == 6'b000111) return RD_POS;
    else if (blk == 6'b111000) return RD_NEG;
    else                       return rd_in;
  endfunction

  function automatic rd_t rd_after_4b(input logic [3:0] blk, input rd_t rd_in);
    int ones;
    ones = $countones(blk);
    if (ones > 2)            return RD_POS;
    else if (ones < 2)       return RD_NEG;
    else if (blk == 4'b0011) return RD_POS;
    else if (blk == 4'b1100) return RD_NEG;
    else                     return rd_in;
  endfunction

endpackage

// File: rtl/pcs_transmit_encoder.sv
// Combinational 8b/10b encoder: 5b/6b then 3b/4b, each sub-block chosen
// by the disparity in effect when it starts.
module encoder_8b10b
  import pcs_transmit_pkg::*;
(
  input  logic [7:0] data,
  input  logic       is_k,
  input  rd_t        rd_in,
  output logic [9:0] code,
  output rd_t        rd_out
);

  // Negative-disparity form of the 6b sub-block; the positive form is its
  // complement whenever the block is unbalanced or is 111000.
  function automatic logic [5:0] code6_neg_of(input logic [4:0] x);
    logic [5:0] r;
    case (x)
      5'd0:  r = 6'b100111;
      5'd1:  r = 6'b011101;
      5'd2:  r = 6'b101101;
      5'd3:  r = 6'b110001;
      5'd4:  r = 6'b110101;
      5'd5:  r = 6'b101001;
      5'd6:  r = 6'b011001;
      5'd7:  r = 6'b111000;
      5'd8:  r = 6'b111001;
      5'd9:  r = 6'b100101;
      5'd10: r = 6'b010101;
      5'd11: r = 6'b110100;
      5'd12: r = 6'b001101;
      5'd13: r = 6'b101100;
      5'd14: r = 6'b011100;
      5'd15: r = 6'b010111;
      5'd16: r = 6'b011011;
      5'd17: r = 6'b100011;
      5'd18: r = 6'b010011;
      5'd19: r = 6'b110010;
      5'd20: r = 6'b001011;
      5'd21: r = 6'b101010;
      5'd22: r = 6'b011010;
      5'd23: r = 6'b111010;
      5'd24: r = 6'b110011;
      5'd25: r = 6'b100110;
      5'd26: r = 6'b010110;
      5'd27: r = 6'b110110;
      5'd28: r = 6'b001110;
      5'd29: r = 6'b101110;
      5'd30: r = 6'b011110;
      default: r = 6'b101011;
    endcase
    return r;
  endfunction

  logic [4:0] x;
  logic [2:0] y;
  logic [5:0] code6_neg;
  logic [5:0] code6;
  logic [3:0] code4_neg;
  logic [3:0] code4;
  logic       flip4;
  logic       use_a7;
  rd_t        rd6;

  assign x = data[4:0];
  assign y = data[7:5];

  always_comb begin
    code6_neg = (is_k && x == 5'd28) ? 6'b001111 : code6_neg_of(x);
    if (rd_in == RD_POS && ($countones(code6_neg) != 3 || code6_neg == 6'b111000))
      code6 = ~code6_neg;
    else
      code6 = code6_neg;
    rd6 = rd_after_6b(code6, rd_in);

    // D.x.A7 avoids a run of five equal bits across the sub-block boundary.
    use_a7 = (rd6 == RD_NEG && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
             (rd6 == RD_POS && (x == 5'd11 || x == 5'd13 || x == 5'd14));

    if (is_k) begin
      case (y)
        3'd0:    code4_neg = 4'b1011;
        3'd1:    code4_neg = 4'b0110;
        3'd2:    code4_neg = 4'b1010;
        3'd3:    code4_neg = 4'b1100;
        3'd4:    code4_neg = 4'b1101;
        3'd5:    code4_neg = 4'b0101;
        3'd6:    code4_neg = 4'b1001;
        default: code4_neg = 4'b0111;
      endcase
      flip4 = (rd6 == RD_POS);
    end else begin
      case (y)
        3'd0:    code4_neg = 4'b1011;
        3'd1:    code4_neg = 4'b1001;
        3'd2:    code4_neg = 4'b0101;
        3'd3:    code4_neg = 4'b1100;
        3'd4:    code4_neg = 4'b1101;
        3'd5:    code4_neg = 4'b1010;
        3'd6:    code4_neg = 4'b0110;
        default: code4_neg = use_a7 ? 4'b0111 : 4'b1110;
      endcase
      flip4 = (rd6 == RD_POS) &&
              ($countones(code4_neg) != 2 || code4_neg == 4'b1100);
    end

    code4  = flip4 ? ~code4_neg : code4_neg;
    rd_out = rd_after_4b(code4, rd6);
    code   = {code6, code4};
  end

endmodule

// File: rtl/pcs_transmit.sv
// 1000BASE-X PCS transmit: turns GMII TX_EN/TXD into one 8b/10b code group
// per clock, framing packets with /S/ /T/ /R/ and filling gaps with /I/.
module pcs_transmit
  import pcs_transmit_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       TX_EN,
  input  logic [7:0] TXD,
  output logic [9:0] tx_code_group,
  output logic       tx_even,
  output logic       transmitting
);

  state_t     state;
  state_t     state_next;
  rd_t        rd;       // disparity entering the group now on tx_code_group
  rd_t        rd_line;  // disparity left behind by that group
  logic [7:0] sym_data;
  logic       sym_k;
  logic       sym_tx;
  logic [9:0] enc_code;
  rd_t        enc_rd_out;

  // The group on the line is always at the opposite parity to the next
  // slot, so tx_even=1 means the group being chosen lands on an odd slot.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no branch
    // can leave one unassigned and infer a latch.
    state_next = state;
    sym_data   = K28_5_OCTET;
    sym_k      = 1'b1;
    sym_tx     = 1'b0;

    case (state)
      XMIT_IDLE: begin
        if (tx_even) begin
          // K28.5 entered negative (left positive): /I2/ restores negative.
          sym_k    = 1'b0;
          sym_data = (rd == RD_NEG) ? D16_2_OCTET : D5_6_OCTET;
        end else if (TX_EN) begin
          sym_data   = K27_7_OCTET;
          sym_tx     = 1'b1;
          state_next = START_PKT;
        end
      end
      START_PKT, TX_DATA: begin
        sym_tx = 1'b1;
        if (TX_EN) begin
          sym_k      = 1'b0;
          sym_data   = TXD;
          state_next = TX_DATA;
        end else begin
          sym_data   = K29_7_OCTET;
          state_next = END_T;
        end
      end
      END_T: begin
        sym_data   = K23_7_OCTET;
        state_next = END_R1;
      end
      END_R1: begin
        if (tx_even) begin
          sym_data   = K23_7_OCTET;
          state_next = END_R2;
        end else begin
          state_next = XMIT_IDLE;
        end
      end
      END_R2: begin
        state_next = XMIT_IDLE;
      end
      default: begin
        state_next = XMIT_IDLE;
      end
    endcase
  end

  encoder_8b10b u_encoder (
    .data   (sym_data),
    .is_k   (sym_k),
    .rd_in  (rd_line),
    .code   (enc_code),
    .rd_out (enc_rd_out)
  );

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments, so every register here sees the
    // pre-edge value of the others regardless of statement order.
    if (reset) begin
      state         <= XMIT_IDLE;
      tx_even       <= 1'b1;
      tx_code_group <= K28_5_NEG;
      transmitting  <= 1'b0;
      rd            <= RD_NEG;
      rd_line       <= RD_POS;
    end else begin
      state         <= state_next;
      tx_even       <= ~tx_even;
      tx_code_group <= enc_code;
      transmitting  <= sym_tx;
      rd            <= rd_line;
      rd_line       <= enc_rd_out;
    end
  end

endmodule

// File: tb/tb_pcs_transmit.sv
// Directed bench for pcs_transmit: a stimulus process queues the expected
// code group for each cycle and a monitor compares it one edge later.
module tb_pcs_transmit;

  localparam logic [9:0] K28_5_N = 10'b0011111010;
  localparam logic [9:0] K28_5_P = 10'b1100000101;
  localparam logic [9:0] D16_2_P = 10'b1001000101;
  localparam logic [9:0] D5_6    = 10'b1010010110;
  localparam logic [9:0] S_N     = 10'b1101101000;
  localparam logic [9:0] T_N     = 10'b1011101000;
  localparam logic [9:0] T_P     = 10'b0100010111;
  localparam logic [9:0] R_N     = 10'b1110101000;
  localparam logic [9:0] R_P     = 10'b0001010111;
  localparam logic [9:0] D21_2   = 10'b1010100101;
  localparam logic [9:0] D21_6   = 10'b1010100110;
  localparam logic [9:0] D1_5_N  = 10'b0111011010;
  localparam logic [9:0] D0_0_N  = 10'b1001110100;
  localparam logic [9:0] D31_7_N = 10'b1010110001;

  typedef struct {
    logic [9:0] code;
    logic       even;
    logic       tx;
    string      name;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       TX_EN;
  logic [7:0] TXD;
  logic [9:0] tx_code_group;
  logic       tx_even;
  logic       transmitting;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  pcs_transmit dut (
    .clk           (clk),
    .reset         (reset),
    .TX_EN         (TX_EN),
    .TXD           (TXD),
    .tx_code_group (tx_code_group),
    .tx_even       (tx_even),
    .transmitting  (transmitting)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [9:0] act, input logic [9:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", nm, act, req);
    end
  endtask

  // Drive one cycle of inputs and queue what must appear after the next edge.
  task automatic step(input logic rst_v, input logic en_v, input logic [7:0] d,
                      input logic [9:0] c, input logic ev, input logic tx,
                      input string nm);
    exp_t e;
    @(negedge clk);
    reset = rst_v;
    TX_EN = en_v;
    TXD   = d;
    e.code = c;
    e.even = ev;
    e.tx   = tx;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, " code"}, tx_code_group, e.code);
        check({e.name, " even"}, {9'b0, tx_even}, {9'b0, e.even});
        check({e.name, " transmitting"}, {9'b0, transmitting}, {9'b0, e.tx});
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    reset = 1'b1;
    TX_EN = 1'b0;
    TXD   = 8'h00;

    // Reset holds K28.5 RD- on an even slot, even with TX_EN asserted.
    step(1, 0, 8'h00, K28_5_N, 1, 0, "rst0");
    step(1, 0, 8'h00, K28_5_N, 1, 0, "rst1");
    step(1, 1, 8'h12, K28_5_N, 1, 0, "rst_txen");

    // Eight idle cycles after release: /K28.5-/ /D16.2+/ pairs.
    step(0, 0, 8'h00, D16_2_P, 0, 0, "idle0");
    step(0, 0, 8'h00, K28_5_N, 1, 0, "idle1");
    step(0, 0, 8'h00, D16_2_P, 0, 0, "idle2");
    step(0, 0, 8'h00, K28_5_N, 1, 0, "idle3");
    step(0, 0, 8'h00, D16_2_P, 0, 0, "idle4");
    step(0, 0, 8'h00, K28_5_N, 1, 0, "idle5");
    step(0, 0, 8'h00, D16_2_P, 0, 0, "idle6");
    step(0, 0, 8'h00, K28_5_N, 1, 0, "idle7");

    // TX_EN rises with the next slot odd: idle pair completes, 0x11 is
    // dropped, /S/ replaces 0x22; /T/ lands odd so a second /R/ follows.
    step(0, 1, 8'h11, D16_2_P, 0, 0, "odd_drop");
    step(0, 1, 8'h22, S_N,     1, 1, "odd_S");
    step(0, 1, 8'h00, D0_0_N,  0, 1, "odd_D0.0");
    step(0, 1, 8'hFF, D31_7_N, 1, 1, "odd_D31.7");
    step(0, 0, 8'h00, T_N,     0, 1, "odd_T");
    step(0, 0, 8'h00, R_N,     1, 0, "odd_R1");
    step(0, 0, 8'h00, R_N,     0, 0, "odd_R2");
    step(0, 0, 8'h00, K28_5_N, 1, 0, "odd_K28.5");
    step(0, 0, 8'h00, D16_2_P, 0, 0, "odd_I2");

    // TX_EN rises with the next slot even: /S/ replaces the first byte.
    // D1.5 leaves RD positive, so /T/ /R/ use RD+ and idle restarts on K28.5+.
    step(0, 1, 8'h07, S_N,     1, 1, "even_S");
    step(0, 1, 8'h55, D21_2,   0, 1, "even_55");
    step(0, 1, 8'hD5, D21_6,   1, 1, "even_D5");
    step(0, 1, 8'hA1, D1_5_N,  0, 1, "even_A1");
    step(0, 0, 8'h00, T_P,     1, 1, "even_T");
    step(0, 0, 8'h00, R_P,     0, 0, "even_R");
    step(0, 0, 8'h00, K28_5_P, 1, 0, "rdpos_K28.5");
    step(0, 0, 8'h00, D5_6,    0, 0, "rdpos_I1");
    step(0, 0, 8'h00, K28_5_N, 1, 0, "rdpos_K28.5b");
    step(0, 0, 8'h00, D16_2_P, 0, 0, "rdpos_I2");

    // One-cycle pulse, then TX_EN reasserted during the end sequence: it is
    // ignored until idle and then handled as an odd-slot edge.
    step(0, 1, 8'h33, S_N,     1, 1, "pulse_S");
    step(0, 0, 8'h00, T_N,     0, 1, "pulse_T");
    step(0, 1, 8'h00, R_N,     1, 0, "pulse_R1");
    step(0, 1, 8'h00, R_N,     0, 0, "pulse_R2");
    step(0, 1, 8'h00, K28_5_N, 1, 0, "reen_K28.5");
    step(0, 1, 8'h44, D16_2_P, 0, 0, "reen_drop");
    step(0, 1, 8'h55, S_N,     1, 1, "reen_S");
    step(0, 1, 8'h55, D21_2,   0, 1, "reen_55");
    step(0, 1, 8'hD5, D21_6,   1, 1, "reen_D5");

    // Reset mid-packet aborts without /T/ and restarts the idle pattern.
    step(1, 1, 8'h00, K28_5_N, 1, 0, "abort_rst");
    step(0, 0, 8'h00, D16_2_P, 0, 0, "abort_I2");
    step(0, 0, 8'h00, K28_5_N, 1, 0, "abort_K28.5");
    step(0, 0, 8'h00, D16_2_P, 0, 0, "abort_I2b");

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
